// File: rtl/z80_reset_ctrl.sv
// Button synchroniser/debouncer with one-cycle press pulses, plus a CPU reset
// sequencer (assert / hold / run) with a sticky run-time timeout flag.
module z80_reset_ctrl #(
  parameter int unsigned NUM_BTN    = 2,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned RST_BTN    = 0,
  parameter int unsigned RST_HOLD   = 64,
  parameter int unsigned TIMEOUT    = 25000
) (
  input  logic               CLK50MHZ,
  input  logic               RESET_N,
  input  logic [NUM_BTN-1:0] BUTTON_N,
  output logic [NUM_BTN-1:0] BTN_STATE,
  output logic [NUM_BTN-1:0] BTN_PRESS,
  output logic               CPU_RESET_N,
  output logic               TIMEOUT_FLAG
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HW = $clog2(RST_HOLD + 1);
  localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [TW-1:0] T_MAX     = TW'(TIMEOUT);
  localparam logic [TW-1:0] T_PRE     = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RUN
  } state_t;

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] r_btn_state;
  logic [NUM_BTN-1:0] r_btn_press;
  logic [DW-1:0]      r_deb_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] w_pressed;

  state_t             r_state;
  logic [HW-1:0]      r_hold_cnt;
  logic [TW-1:0]      r_tmo_cnt;
  logic               r_cpu_reset_n;
  logic               r_timeout_flag;
  logic               w_rst_btn;

  assign w_pressed = ~r_sync2;
  assign w_rst_btn = r_btn_state[RST_BTN];

  // Synchronise, then flip the debounced level after DEB_CYCLES consecutive mismatches
  always_ff @(posedge CLK50MHZ) begin
    if (!RESET_N) begin
      r_sync1     <= '1;
      r_sync2     <= '1;
      r_btn_state <= '0;
      r_btn_press <= '0;
      for (int i = 0; i < NUM_BTN; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1     <= BUTTON_N;
      r_sync2     <= r_sync1;
      r_btn_press <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (w_pressed[i] == r_btn_state[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_btn_state[i] <= w_pressed[i];
          r_btn_press[i] <= w_pressed[i];
          r_deb_cnt[i]   <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Reset sequencer; a held reset button overrides every state
  always_ff @(posedge CLK50MHZ) begin
    if (!RESET_N) begin
      r_state        <= ST_ASSERT;
      r_hold_cnt     <= '0;
      r_tmo_cnt      <= '0;
      r_cpu_reset_n  <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else if (w_rst_btn) begin
      r_state        <= ST_ASSERT;
      r_hold_cnt     <= '0;
      r_tmo_cnt      <= '0;
      r_cpu_reset_n  <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          r_state    <= ST_HOLD;
          r_hold_cnt <= '0;
        end
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state       <= ST_RUN;
            r_tmo_cnt     <= '0;
            r_cpu_reset_n <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        ST_RUN: begin
          if (TIMEOUT != 0 && r_tmo_cnt != T_MAX) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
            if (r_tmo_cnt == T_PRE) r_timeout_flag <= 1'b1;
          end
        end
        default: begin
          r_state       <= ST_ASSERT;
          r_cpu_reset_n <= 1'b0;
        end
      endcase
    end
  end

  assign BTN_STATE    = r_btn_state;
  assign BTN_PRESS    = r_btn_press;
  assign CPU_RESET_N  = r_cpu_reset_n;
  assign TIMEOUT_FLAG = r_timeout_flag;

endmodule

// File: tb/tb_z80_reset_ctrl.sv
// Bench for z80_reset_ctrl: directed scenarios plus random buttons, checked
// against a sample-window debounce model and a time-since-assert reset model.
module tb_z80_reset_ctrl;

  localparam int NB   = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int TO   = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_n = '1;
  logic [NB-1:0] st, pr, st0, pr0;
  logic          cpu, flg, cpu0, flg0;

  int checks = 0;
  int errors = 0;

  z80_reset_ctrl #(.NUM_BTN(NB), .DEB_CYCLES(DEB), .RST_BTN(0), .RST_HOLD(HOLD), .TIMEOUT(TO)) dut (
    .CLK50MHZ(clk), .RESET_N(rst_n), .BUTTON_N(btn_n),
    .BTN_STATE(st), .BTN_PRESS(pr), .CPU_RESET_N(cpu), .TIMEOUT_FLAG(flg));

  z80_reset_ctrl #(.NUM_BTN(NB), .DEB_CYCLES(DEB), .RST_BTN(0), .RST_HOLD(HOLD), .TIMEOUT(0)) dut0 (
    .CLK50MHZ(clk), .RESET_N(rst_n), .BUTTON_N(btn_n),
    .BTN_STATE(st0), .BTN_PRESS(pr0), .CPU_RESET_N(cpu0), .TIMEOUT_FLAG(flg0));

  always #5 clk = ~clk;

  // Model: p_q[j] is the pressed vector sampled j+1 edges ago; a = last edge forced into ASSERT
  logic [NB-1:0] p_q[$];
  logic [NB-1:0] m_state = '0;
  logic [NB-1:0] m_press = '0;
  int k = 0;
  int a = 0;

  function automatic logic exp_cpu();
    return (k - a) >= HOLD + 1;
  endfunction

  function automatic logic exp_flag();
    return (k - a) >= HOLD + 1 + TO;
  endfunction

  task automatic tick();
    logic [NB-1:0] prev, v;
    bit flip;
    @(posedge clk);
    k++;
    if (!rst_n) begin
      p_q.delete();
      for (int j = 0; j <= DEB; j++) p_q.push_back('0);
      m_state = '0;
      m_press = '0;
      a = k;
    end else begin
      prev = m_state;
      if (prev[0]) a = k;
      for (int i = 0; i < NB; i++) begin
        flip = 1'b1;
        for (int j = 1; j <= DEB; j++) begin
          v = p_q[j];
          if (v[i] == prev[i]) flip = 1'b0;
        end
        m_state[i] = flip ? ~prev[i] : prev[i];
        m_press[i] = flip && !prev[i];
      end
      p_q.push_front(~btn_n);
      void'(p_q.pop_back());
    end
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    btn_n = 2'b11;
    repeat (3) begin
      tick();
      checks++;
      if ({st, pr, cpu, flg} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs: got %b expected 000000", {st, pr, cpu, flg});
      end
    end
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      checks++;
      if (cpu !== exp_cpu()) begin
        errors++;
        $display("FAIL powerup_cpu: got %b expected %b at edge %0d", cpu, exp_cpu(), n);
      end
    end while (cpu !== 1'b1 && n < 40);
    checks++;
    if (n !== HOLD + 1) begin
      errors++;
      $display("FAIL powerup_release_edge: got %0d expected %0d", n, HOLD + 1);
    end
    n = 0;
    do begin
      tick();
      n++;
      checks++;
      if (flg !== exp_flag()) begin
        errors++;
        $display("FAIL timeout_flag: got %b expected %b at edge %0d", flg, exp_flag(), n);
      end
    end while (flg !== 1'b1 && n < 200);
    checks++;
    if (n !== TO) begin
      errors++;
      $display("FAIL timeout_edge: got %0d expected %0d", n, TO);
    end
  endtask

  task automatic test_press();
    int rise, npress, fall, n;
    rise = -1;
    npress = 0;
    btn_n = 2'b01;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (st[1] === 1'b1 && rise < 0) rise = t;
      if (pr[1] === 1'b1) begin
        npress++;
        checks++;
        if (t !== rise) begin
          errors++;
          $display("FAIL press_align: got pulse at %0d expected %0d", t, rise);
        end
      end
      checks++;
      if ({st, pr} !== {m_state, m_press}) begin
        errors++;
        $display("FAIL press_model: got %b expected %b", {st, pr}, {m_state, m_press});
      end
    end
    checks++;
    if (rise !== DEB + 2) begin
      errors++;
      $display("FAIL press_rise_edge: got %0d expected %0d", rise, DEB + 2);
    end
    checks++;
    if (npress !== 1) begin
      errors++;
      $display("FAIL press_pulse_count: got %0d expected 1", npress);
    end
    btn_n = 2'b11;
    fall = -1;
    for (n = 1; n <= 20; n++) begin
      tick();
      checks++;
      if (pr !== 2'b00) begin
        errors++;
        $display("FAIL release_no_pulse: got %b expected 00", pr);
      end
      if (st[1] === 1'b0 && fall < 0) fall = n;
    end
    checks++;
    if (fall !== DEB + 2) begin
      errors++;
      $display("FAIL release_fall_edge: got %0d expected %0d", fall, DEB + 2);
    end
  endtask

  task automatic test_glitch();
    for (int t = 0; t < 73; t++) begin
      if (t < 3) btn_n = 2'b01;
      else if (t < 13) btn_n = 2'b11;
      else if (t < 43) btn_n = ((t - 13) % 4 < 2) ? 2'b01 : 2'b11;
      else btn_n = 2'b11;
      tick();
      checks++;
      if ({st[1], pr[1]} !== 2'b00 || {st, pr} !== {m_state, m_press}) begin
        errors++;
        $display("FAIL glitch_reject: got st=%b pr=%b expected st=00 pr=00", st, pr);
      end
    end
  endtask

  task automatic test_reset_pulse();
    int r, f, d, u;
    logic flag_at_f;
    r = -1; f = -1; d = -1; u = -1;
    flag_at_f = 1'b1;
    checks++;
    if (flg !== 1'b1 || exp_flag() !== 1'b1) begin
      errors++;
      $display("FAIL pulse_pre_flag: got %b expected 1", flg);
    end
    for (int t = 1; t <= 40; t++) begin
      btn_n = (t <= 5) ? 2'b10 : 2'b11;
      tick();
      if (st[0] === 1'b1 && r < 0) r = t;
      if (r > 0 && st[0] === 1'b0 && d < 0) d = t;
      if (cpu === 1'b0 && f < 0) begin
        f = t;
        flag_at_f = flg;
      end
      if (f > 0 && cpu === 1'b1 && u < 0) u = t;
      checks++;
      if ({cpu, flg} !== {exp_cpu(), exp_flag()}) begin
        errors++;
        $display("FAIL pulse_model: got cpu=%b flag=%b expected cpu=%b flag=%b", cpu, flg, exp_cpu(), exp_flag());
      end
    end
    checks++;
    if (r !== DEB + 2 || d !== DEB + 7) begin
      errors++;
      $display("FAIL pulse_btn_edges: got rise=%0d fall=%0d expected rise=%0d fall=%0d", r, d, DEB + 2, DEB + 7);
    end
    checks++;
    if (f !== r + 1) begin
      errors++;
      $display("FAIL pulse_cpu_fall: got %0d expected %0d", f, r + 1);
    end
    checks++;
    if (u !== d + HOLD + 1) begin
      errors++;
      $display("FAIL pulse_cpu_rise: got %0d expected %0d", u, d + HOLD + 1);
    end
    checks++;
    if (flag_at_f !== 1'b0) begin
      errors++;
      $display("FAIL pulse_flag_clear: got %b expected 0", flag_at_f);
    end
  endtask

  task automatic test_mid_hold();
    int n, rr, rf, u;
    bit early;
    btn_n = 2'b10;
    n = 0;
    do begin tick(); n++; end while (st[0] !== 1'b1 && n < 20);
    repeat (3) tick();
    btn_n = 2'b11;
    n = 0;
    do begin tick(); n++; end while (st[0] !== 1'b0 && n < 20);
    checks++;
    if (n !== DEB + 2) begin
      errors++;
      $display("FAIL midhold_first_fall: got %0d expected %0d", n, DEB + 2);
    end
    rr = -1; rf = -1; u = -1;
    early = 1'b0;
    btn_n = 2'b10;
    for (int t = 1; t <= 30; t++) begin
      if (t == 5) btn_n = 2'b11;
      tick();
      if (st[0] === 1'b1 && rr < 0) rr = t;
      if (rr > 0 && st[0] === 1'b0 && rf < 0) rf = t;
      if (cpu === 1'b1 && u < 0) u = t;
      if (cpu === 1'b1 && t < 19) early = 1'b1;
      checks++;
      if (cpu !== exp_cpu()) begin
        errors++;
        $display("FAIL midhold_cpu: got %b expected %b at edge %0d", cpu, exp_cpu(), t);
      end
    end
    checks++;
    if (rr !== 6 || rf !== 10) begin
      errors++;
      $display("FAIL midhold_btn_edges: got rise=%0d fall=%0d expected rise=6 fall=10", rr, rf);
    end
    checks++;
    if (early !== 1'b0 || u !== 19) begin
      errors++;
      $display("FAIL midhold_release: got rise=%0d early=%b expected rise=19 early=0", u, early);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int s = 0; s < 60; s++) begin
      btn_n = 2'($urandom);
      rst_n = ($urandom_range(0, 19) != 0);
      hold = $urandom_range(1, 10);
      repeat (hold) begin
        tick();
        rst_n = 1'b1;
        checks++;
        if ({st, pr, cpu, flg} !== {m_state, m_press, exp_cpu(), exp_flag()}) begin
          errors++;
          $display("FAIL rnd_dut: got %b expected %b at edge %0d", {st, pr, cpu, flg},
                   {m_state, m_press, exp_cpu(), exp_flag()}, k);
        end
        checks++;
        if ({st0, pr0, cpu0, flg0} !== {m_state, m_press, exp_cpu(), 1'b0}) begin
          errors++;
          $display("FAIL rnd_dut0: got %b expected %b at edge %0d", {st0, pr0, cpu0, flg0},
                   {m_state, m_press, exp_cpu(), 1'b0}, k);
        end
      end
    end
    btn_n = 2'b11;
    rst_n = 1'b1;
    repeat (20) tick();
  endtask

  task automatic test_timeout0();
    rst_n = 1'b0;
    btn_n = 2'b11;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int t = 0; t < 1100; t++) begin
      tick();
      checks++;
      if (flg0 !== 1'b0 || flg !== exp_flag()) begin
        errors++;
        $display("FAIL timeout0_flag: got flag0=%b flag=%b expected flag0=0 flag=%b", flg0, flg, exp_flag());
      end
    end
    checks++;
    if (cpu0 !== 1'b1) begin
      errors++;
      $display("FAIL timeout0_run: got cpu=%b expected 1", cpu0);
    end
  endtask

  initial begin
    for (int j = 0; j <= DEB; j++) p_q.push_back('0);
    test_reset();
    test_press();
    test_glitch();
    test_reset_pulse();
    test_mid_hold();
    test_random();
    test_timeout0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80_reset_ctrl.md
# z80_reset_ctrl

Parametrised button debouncer and reset sequencer for the Z80 system top. It synchronises and debounces `NUM_BTN` raw active-low push buttons and emits one-cycle press pulses. It generates a stretched, glitch-free CPU reset from a selectable button and flags a run-time cycle timeout. It sits between the board/bench button inputs and the CPU, memory and peripheral reset nets, replacing direct wiring of the raw reset button.

## Interface
Parameters:
- `NUM_BTN`, 2: number of button inputs (1..8).
- `DEB_CYCLES`, 16: consecutive stable sampled cycles required to accept a change (>=1).
- `RST_BTN`, 0: index of the button that drives CPU reset (< `NUM_BTN`).
- `RST_HOLD`, 64: cycles `CPU_RESET_N` stays low after the reset button is released (>=1).
- `TIMEOUT`, 25000: `RUN` cycles before `TIMEOUT_FLAG` sets; 0 disables.

Ports:
- `CLK50MHZ`, in, 1: the single clock; all logic on rising edge.
- `RESET_N`, in, 1: synchronous, active-low block reset.
- `BUTTON_N`, in, `NUM_BTN`: raw asynchronous buttons, low = pressed.
- `BTN_STATE`, out, `NUM_BTN`: debounced level, high = pressed.
- `BTN_PRESS`, out, `NUM_BTN`: one-cycle pulse on each debounced press.
- `CPU_RESET_N`, out, 1: registered, active-low system reset.
- `TIMEOUT_FLAG`, out, 1: sticky, set when `RUN` lasts `TIMEOUT` cycles.

## Operation
- Per button: 2-flop synchroniser, then a debounce counter of width clog2(`DEB_CYCLES`+1).
- Counter behaviour:
  - Increments while the synchronised level differs from the current debounced state.
  - Clears when the synchronised level matches the state.
  - When it reaches `DEB_CYCLES`-1 with a mismatch, the state flips and the counter clears.
- `BTN_PRESS[i]` is high exactly in the cycle `BTN_STATE[i]` first reads 1. It is registered alongside `BTN_STATE`. Releases produce no pulse.
- Reset FSM, 3 states:
  - `ASSERT`: `CPU_RESET_N`=0. Stays while `BTN_STATE[RST_BTN]`=1. Otherwise goes to `HOLD` and clears the hold counter.
  - `HOLD`: `CPU_RESET_N`=0. Hold counter increments each cycle. At `RST_HOLD`-1, goes to `RUN`.
  - `RUN`: `CPU_RESET_N`=1. Timeout counter increments, saturating at `TIMEOUT`.
- `BTN_STATE[RST_BTN]`=1 in any state forces `ASSERT` on the next edge. This includes mid-`HOLD`, where the hold count is discarded.
- `TIMEOUT_FLAG` sets when the timeout counter reaches `TIMEOUT`, stays set through `RUN`, and clears on entry to `ASSERT`. With `TIMEOUT`=0 it never sets.
- `RESET_N`=0 at an edge sets:
  - synchroniser flops to 1 (released)
  - `BTN_STATE`=0, `BTN_PRESS`=0, all counters 0
  - FSM=`ASSERT`, `CPU_RESET_N`=0, `TIMEOUT_FLAG`=0

## Timing
- Outputs in reset: `BTN_STATE`=0, `BTN_PRESS`=0, `CPU_RESET_N`=0, `TIMEOUT_FLAG`=0.
- Debounce latency: a raw change stable from sampling edge 1 updates `BTN_STATE` on edge `DEB_CYCLES`+2.
- Glitches: a raw pulse stable for fewer than `DEB_CYCLES` synchronised cycles never reaches `BTN_STATE`.
- Reset release: `CPU_RESET_N` rises exactly `RST_HOLD`+1 edges after the edge where `BTN_STATE[RST_BTN]` falls to 0 (1 edge into `HOLD`, then `RST_HOLD` edges).
- Reset press: `CPU_RESET_N` falls 1 edge after `BTN_STATE[RST_BTN]` rises.
- Timeout: `TIMEOUT_FLAG` rises on the `TIMEOUT`-th edge after `CPU_RESET_N` rises.
- Simultaneous events: if `RESET_N`=0 and a button change land on the same edge, reset wins. Independent buttons changing on the same edge are handled in parallel.

## Test plan
Default bench parameters: `DEB_CYCLES`=4, `RST_HOLD`=8, `TIMEOUT`=100, `NUM_BTN`=2.
- Power-up: `RESET_N`=0 for 3 cycles with `BUTTON_N`=2'b11, then `RESET_N`=1 -> `CPU_RESET_N` low for the 1 `ASSERT` edge plus 8 `HOLD` edges, then 1. `TIMEOUT_FLAG` rises 100 edges later.
- Debounced press: `BUTTON_N[1]` low for 20 cycles -> `BTN_STATE[1]` rises on edge 6. `BTN_PRESS[1]` is high for exactly that 1 cycle. `BTN_STATE[1]` falls 6 edges after release.
- Glitch reject: `BUTTON_N[1]` low for 3 cycles, and separately a bounce train toggling every 2 cycles for 30 cycles -> `BTN_STATE[1]`=0 and no `BTN_PRESS`.
- Bench-style reset pulse: `BUTTON_N`=2'b10 for 5 cycles in `RUN` -> `CPU_RESET_N` falls 1 edge after `BTN_STATE[0]` rises, rises 9 edges after `BTN_STATE[0]` falls, and `TIMEOUT_FLAG` clears.
- Reset mid-`HOLD`: re-press the reset button at hold count 5 -> FSM returns to `ASSERT`. The full 8-cycle hold restarts after release, with no early `CPU_RESET_N` rise.
- `TIMEOUT`=0 build: run 1000 cycles in `RUN` -> `TIMEOUT_FLAG` stays 0.
